// File: rtl/cache_pkg.sv
// Shared types and width helpers for the write-back set-associative data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_t;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    // Number of address bits a field occupies (may be zero).
    function automatic int field_bits(input int n);
        return $clog2(n);
    endfunction

    // Vector width able to hold values 0..n-1, never narrower than one bit.
    function automatic int vec_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_data_align.sv
// Byte-lane steering: load extraction with sign/zero extension and store byte-enable merge.
module cache_data_align
    import cache_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  ls_type,
    input  logic        load_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [3:0]  byte_en;
    logic [31:0] store_rep;

    always_comb begin
        byte_val = word_in[{byte_off, 3'b000} +: 8];
        half_val = byte_off[1] ? word_in[31:16] : word_in[15:0];
        case (ls_type)
            LS_BYTE: load_data = load_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            LS_HALF: load_data = load_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_data = word_in;
        endcase
    end

    // Store data arrives right-aligned; replicate it so every enabled lane sees the right bits.
    always_comb begin
        case (ls_type)
            LS_BYTE: begin
                byte_en   = 4'b0001 << byte_off;
                store_rep = {4{store_data[7:0]}};
            end
            LS_HALF: begin
                byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{store_data[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                store_rep = store_data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en[i] ? store_rep[8*i +: 8] : word_in[8*i +: 8];
        end
    end

endmodule

// File: rtl/set_assc_cache_wb.sv
// N-way set-associative write-back, write-allocate data cache with age-based LRU and a
// word-serial backing bus used for dirty write-back followed by line refill.
module set_assc_cache_wb
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CACHE_LOCS = 16,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            load_store_type,
    input  logic                  load_unsigned,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  cache_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic [1:0]            dbg_state
);

    localparam int NUM_SETS = NUM_CACHE_LOCS / (NUM_WAYS * WORDS_PER_LINE);
    localparam int WOFF_B   = field_bits(WORDS_PER_LINE);
    localparam int IDX_B    = field_bits(NUM_SETS);
    localparam int TAG_B    = ADDR_WIDTH - 2 - WOFF_B - IDX_B;
    localparam int IDX_SH   = 2 + WOFF_B;
    localparam int TAG_SH   = IDX_SH + IDX_B;
    localparam int WOFF_W   = vec_width(WORDS_PER_LINE);
    localparam int IDX_W    = vec_width(NUM_SETS);
    localparam int WAY_W    = vec_width(NUM_WAYS);
    localparam logic [WAY_W-1:0]  AGE_MAX   = WAY_W'(NUM_WAYS - 1);
    localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORDS_PER_LINE - 1);

    cache_state_t state_q, state_d;

    logic [TAG_B-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic                  valid_q [NUM_SETS][NUM_WAYS];
    logic                  dirty_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

    logic [WOFF_W-1:0]     woff, cnt_q;
    logic [IDX_W-1:0]      idx;
    logic [TAG_B-1:0]      tag;
    logic [WAY_W-1:0]      hit_way, vic_way, vic_q, acc_way, best_age;
    logic [WAY_W-1:0]      age_d [NUM_WAYS];
    logic                  req, hit, vic_dirty, last_ack, store_hit, fill_done, acc_en;
    logic [DATA_WIDTH-1:0] load_val, merged;
    logic [ADDR_WIDTH-1:0] wb_addr, rf_addr;

    assign woff = WOFF_W'((mem_addr >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
    assign idx  = IDX_W'((mem_addr >> IDX_SH) & ADDR_WIDTH'(NUM_SETS - 1));
    assign tag  = TAG_B'(mem_addr >> TAG_SH);
    assign req  = mem_read | mem_write;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way wins; otherwise the oldest, ties to the lowest index.
    always_comb begin
        vic_way  = '0;
        best_age = age_q[idx][0];
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (age_q[idx][w] > best_age) begin
                best_age = age_q[idx][w];
                vic_way  = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) vic_way = WAY_W'(w);
        end
    end

    assign vic_dirty = valid_q[idx][vic_way] && dirty_q[idx][vic_way];
    assign last_ack  = bus_ack && (state_q != IDLE) && (cnt_q == LAST_WORD);
    assign store_hit = (state_q == IDLE) && mem_write && hit;
    assign fill_done = (state_q == REFILL) && last_ack;
    assign acc_en    = ((state_q == IDLE) && req && hit) || fill_done;
    assign acc_way   = (state_q == IDLE) ? hit_way : vic_q;

    // Ways not older than the accessed one age by one, so the accessed way becomes youngest.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_d[w] = age_q[idx][w];
            if (WAY_W'(w) == acc_way) begin
                age_d[w] = '0;
            end else if (age_q[idx][w] <= age_q[idx][acc_way] && age_q[idx][w] != AGE_MAX) begin
                age_d[w] = age_q[idx][w] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req && !hit) state_d = vic_dirty ? WRITEBACK : REFILL;
            WRITEBACK: if (last_ack)    state_d = REFILL;
            REFILL:    if (last_ack)    state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    assign wb_addr = (ADDR_WIDTH'(tag_q[idx][vic_q]) << TAG_SH) | (ADDR_WIDTH'(idx) << IDX_SH)
                   | (ADDR_WIDTH'(cnt_q) << 2);
    assign rf_addr = (ADDR_WIDTH'(tag) << TAG_SH) | (ADDR_WIDTH'(idx) << IDX_SH)
                   | (ADDR_WIDTH'(cnt_q) << 2);

    // Bus handshake: bus_req/bus_we/bus_addr/bus_wdata stay stable while bus_req is high until
    // the single-cycle bus_ack; the following word is presented on the cycle after the ack.
    always_comb begin
        cache_stall = (state_q != IDLE) || (req && !hit);
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        case (state_q)
            WRITEBACK: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = wb_addr;
                bus_wdata = data_q[idx][vic_q][cnt_q];
            end
            REFILL: begin
                bus_req  = 1'b1;
                bus_addr = rf_addr;
            end
            default: ;
        endcase
    end

    assign dbg_state     = state_q;
    assign mem_read_data = ((state_q == IDLE) && mem_read && hit) ? load_val : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            vic_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
            if (req && !hit) vic_q <= vic_way;
        end else if (bus_ack) begin
            cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + WOFF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            if (store_hit) dirty_q[idx][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_q[idx][vic_q] <= 1'b1;
                dirty_q[idx][vic_q] <= 1'b0;
            end
            if (acc_en) begin
                for (int w = 0; w < NUM_WAYS; w++) age_q[idx][w] <= age_d[w];
            end
        end
    end

    // Tag and data storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (store_hit) data_q[idx][hit_way][woff] <= merged;
        if (state_q == REFILL && bus_ack) data_q[idx][vic_q][cnt_q] <= bus_rdata;
        if (fill_done) tag_q[idx][vic_q] <= tag;
    end

    cache_data_align u_align (
        .word_in       (data_q[idx][hit_way][woff]),
        .store_data    (mem_write_data),
        .byte_off      (mem_addr[1:0]),
        .ls_type       (load_store_type),
        .load_unsigned (load_unsigned),
        .load_data     (load_val),
        .merged        (merged)
    );

endmodule

// File: tb/tb_set_assc_cache_wb.sv
// Bench for set_assc_cache_wb: byte-addressed memory model with recency-ordered sets, a
// latency-2 backing-bus responder and an expected-transaction queue for bus traffic.
module tb_set_assc_cache_wb;
    import cache_pkg::*;

    localparam int ACK_LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mem_addr = '0, mem_write_data = '0, mem_read_data;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
    logic [1:0]  load_store_type = 2'b00;
    logic        cache_stall, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [1:0]  dbg_state;

    set_assc_cache_wb dut (
        .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .load_store_type(load_store_type),
        .load_unsigned(load_unsigned), .mem_read_data(mem_read_data), .cache_stall(cache_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Backing store (word) and the CPU-visible truth (byte), plus the cache directory model.
    logic [31:0] bmem [0:255];
    logic [7:0]  fmem [0:1023];
    int          m_tag   [4][2];
    bit          m_valid [4][2];
    bit          m_dirty [4][2];
    int          recency [4][2];
    logic [64:0] exp_q [$];

    function automatic logic [31:0] word_at(input int a);
        return {fmem[a + 3], fmem[a + 2], fmem[a + 1], fmem[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) {fmem[4*i+3], fmem[4*i+2], fmem[4*i+1], fmem[4*i]} = bmem[i];
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                recency[s][w] = w;
            end
        end
        exp_q.delete();
    endtask

    task automatic touch(input int s, input int w);
        if (recency[s][1] != w) begin
            recency[s][0] = recency[s][1];
            recency[s][1] = w;
        end
    endtask

    task automatic model_access(input int a, input bit is_store, output bit miss);
        int s, t, way, old_base, new_base;
        s = (a >> 3) % 4;
        t = a >> 5;
        way = -1;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        miss = (way < 0);
        if (miss) begin
            way = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : recency[s][0]);
            if (m_valid[s][way] && m_dirty[s][way]) begin
                old_base = m_tag[s][way] * 32 + s * 8;
                exp_q.push_back({1'b1, 32'(old_base), word_at(old_base)});
                exp_q.push_back({1'b1, 32'(old_base + 4), word_at(old_base + 4)});
            end
            new_base = a - (a % 8);
            exp_q.push_back({1'b0, 32'(new_base), 32'h0});
            exp_q.push_back({1'b0, 32'(new_base + 4), 32'h0});
            m_tag[s][way] = t;
            m_valid[s][way] = 1;
            m_dirty[s][way] = 0;
        end
        if (is_store) m_dirty[s][way] = 1;
        touch(s, way);
    endtask

    function automatic logic [31:0] model_load(input int a, input logic [1:0] ls, input bit uns);
        logic [7:0]  b;
        logic [15:0] h;
        if (ls == LS_BYTE) begin
            b = fmem[a];
            return uns ? 32'(b) : 32'(signed'(b));
        end else if (ls == LS_HALF) begin
            h = {fmem[a - (a % 2) + 1], fmem[a - (a % 2)]};
            return uns ? 32'(h) : 32'(signed'(h));
        end
        return word_at(a - (a % 4));
    endfunction

    task automatic model_store(input int a, input logic [1:0] ls, input logic [31:0] d);
        int base;
        if (ls == LS_BYTE) begin
            fmem[a] = d[7:0];
        end else if (ls == LS_HALF) begin
            base = a - (a % 2);
            fmem[base] = d[7:0];
            fmem[base + 1] = d[15:8];
        end else begin
            base = a - (a % 4);
            for (int i = 0; i < 4; i++) fmem[base + i] = d[8*i +: 8];
        end
    endtask

    // Compare process: idle outputs, stall prediction on each new request, load data on completion.
    bit prev_pending = 0;
    bit exp_miss;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_pending = 0;
        end else if (!(mem_read || mem_write)) begin
            check("idle_stall", 32'(cache_stall), 32'h0);
            check("idle_rdata", mem_read_data, 32'h0);
            prev_pending = 0;
        end else begin
            if (!prev_pending) begin
                model_access(int'(mem_addr), mem_write, exp_miss);
                check("stall_on_request", 32'(cache_stall), 32'(exp_miss));
            end
            if (!cache_stall) begin
                if (mem_write) model_store(int'(mem_addr), load_store_type, mem_write_data);
                else check("load_data", mem_read_data, model_load(int'(mem_addr), load_store_type, load_unsigned));
            end
            prev_pending = cache_stall;
        end
    end

    // Backing-bus responder: ack on the ACK_LAT-th cycle of each word, scoreboard on each ack.
    int          wait_cnt = 0, wb_count = 0, rf_count = 0;
    logic [31:0] last_wb_addr = '0;
    logic [64:0] exp_e;
    bit          glitch = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                if (wait_cnt == ACK_LAT - 1) begin
                    wait_cnt = 0;
                    bus_ack = 1'b1;
                    if (bus_we) begin
                        bmem[bus_addr[9:2]] = bus_wdata;
                        wb_count++;
                        last_wb_addr = bus_addr;
                    end else begin
                        bus_rdata = bmem[bus_addr[9:2]];
                        rf_count++;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bus_unexpected: got addr 0x%08h we %0d expected no transfer", bus_addr, bus_we);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("bus_we", 32'(bus_we), 32'(exp_e[64]));
                        check("bus_addr", bus_addr, exp_e[63:32]);
                        if (exp_e[64]) check("bus_wdata", bus_wdata, exp_e[31:0]);
                    end
                end else begin
                    bus_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                bus_ack = glitch;
                bus_rdata = glitch ? 32'hDEADBEEF : 32'h0;
            end
        end
    end

    int          last_stall;
    logic [31:0] last_rdata;
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] ls,
                          input bit uns, input logic [31:0] wd);
        bit done;
        mem_read = rd; mem_write = wr; mem_addr = a;
        load_store_type = ls; load_unsigned = uns; mem_write_data = wd;
        last_stall = 0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!cache_stall) done = 1;
            else last_stall++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: got stall held at addr 0x%08h expected release", a);
        end
        last_rdata = mem_read_data;
        @(posedge clk);
        #1;
        mem_read = 0;
        mem_write = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] ls, input bit uns);
        access(1, 0, a, ls, uns, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] ls, input logic [31:0] d);
        access(0, 1, a, ls, 0, d);
    endtask

    int wb0;
    bit got_ack;
    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = 32'h10000000 + i;
        bmem[16] = 32'h800000F1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(cache_stall), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_rdata", mem_read_data, 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        @(posedge clk); #1 rstn = 1;
        @(posedge clk); #1;

        // Cold miss with clean refill of 0x40/0x44.
        load(32'h40, LS_WORD, 0);
        check("t1_stall", last_stall, 5);
        check("t1_data", last_rdata, 32'h800000F1);
        check("t1_refills", rf_count, 2);

        // Byte store then signed/unsigned byte loads, all hits.
        store(32'h41, LS_BYTE, 32'hFFFFFFAB);
        check("t2_store_stall", last_stall, 0);
        load(32'h41, LS_BYTE, 0);
        check("t2_signed", last_rdata, 32'hFFFFFFAB);
        load(32'h41, LS_BYTE, 1);
        check("t2_unsigned", last_rdata, 32'h000000AB);
        load(32'h43, LS_BYTE, 0);
        check("t2_byte3", last_rdata, 32'hFFFFFF80);
        check("t2_no_bus", rf_count + wb_count, 2);

        // Set 0 fills: 0x20 dirty, 0x00 evicts dirty 0x40, touch 0x00, then 0x40 evicts 0x20.
        store(32'h20, LS_WORD, 32'h12345678);
        load(32'h00, LS_WORD, 0);
        check("t3_wb_stall", last_stall, 9);
        check("t3_wb_last", last_wb_addr, 32'h44);
        load(32'h00, LS_WORD, 0);
        check("t3_touch_hit", last_stall, 0);
        wb0 = wb_count;
        load(32'h40, LS_WORD, 0);
        check("t3_evict_writes", wb_count - wb0, 2);
        check("t3_evict_addr", last_wb_addr, 32'h24);
        check("t3_reload", last_rdata, 32'h8000ABF1);

        // Half-word extraction.
        store(32'h40, LS_WORD, 32'h80017FFF);
        load(32'h42, LS_HALF, 0);
        check("t4_half_hi", last_rdata, 32'hFFFF8001);
        load(32'h40, LS_HALF, 0);
        check("t4_half_lo", last_rdata, 32'h00007FFF);
        load(32'h43, LS_HALF, 0);
        check("t4_half_odd", last_rdata, 32'hFFFF8001);
        load(32'h42, LS_HALF, 1);
        check("t4_half_uns", last_rdata, 32'h00008001);

        // Stray ack while idle, then read+write together on a hit.
        @(negedge clk); glitch = 1;
        @(negedge clk); glitch = 0;
        check("t6_glitch_state", 32'(dbg_state), 32'h0);
        check("t6_glitch_req", 32'(bus_req), 32'h0);
        @(posedge clk); #1;
        access(1, 1, 32'h44, LS_WORD, 0, 32'h0BADF00D);
        check("t6_both_stall", last_stall, 0);
        load(32'h44, LS_WORD, 0);
        check("t6_both_data", last_rdata, 32'h0BADF00D);
        wb0 = wb_count;
        load(32'h60, LS_WORD, 0);
        check("t6_clean_evict", wb_count - wb0, 0);
        load(32'h00, LS_WORD, 0);
        check("t6_dirty_evict", wb_count - wb0, 2);
        load(32'h44, LS_WORD, 0);
        check("t6_backed", last_rdata, 32'h0BADF00D);

        // Reset during the second refill word.
        mem_read = 1; mem_write = 0; mem_addr = 32'h88; load_store_type = LS_WORD; load_unsigned = 0;
        got_ack = 0;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clk);
            got_ack = bus_ack;
        end
        check("t5_first_ack", 32'(got_ack), 32'h1);
        @(posedge clk); #1;
        check("t5_word1_addr", bus_addr, 32'h8C);
        rstn = 0; mem_read = 0;
        model_reset();
        @(negedge clk);
        check("t5_rst_stall", 32'(cache_stall), 32'h0);
        check("t5_rst_req", 32'(bus_req), 32'h0);
        check("t5_rst_state", 32'(dbg_state), 32'h0);
        @(posedge clk); #1 rstn = 1;
        @(posedge clk); #1;
        load(32'h88, LS_WORD, 0);
        check("t5_full_miss", last_stall, 5);
        check("t5_data", last_rdata, 32'h10000022);

        repeat (3) @(posedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
